// File: rtl/timer_sched_pkg.sv
// Shared types and helpers for the timer_sched slice: FSM state encoding,
// index width and the one-hot to index conversion used by the arbiter.
package timer_sched_pkg;

  localparam int N_MAX = 16;
  localparam int IDX_W = $clog2(N_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Callers guarantee at most one bit is set, so OR-ing indices is exact.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_MAX-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_MAX; i++) begin
      if (oh[i]) r = r | IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_sched_if.sv
// Client-side bundle of timer_sched: request/delay/abort/tick inputs and
// grant/done/status outputs, plus the FSM state for observation.
interface timer_sched_if #(
    parameter int N    = 4,
    parameter int BITS = 4
);
  // Handshake: a client holds req high until it sees gnt; the counter then
  // belongs to it until a one-cycle done pulse (or an abort drops gnt).
  // delay is sampled only on the cycle the grant is taken.
  logic                tick_en;
  logic [N-1:0]        req;
  logic [N*BITS-1:0]   delay;
  logic                abort;
  logic [N-1:0]        gnt;
  logic [N-1:0]        done;
  logic                busy;
  logic [BITS-1:0]     count;
  logic [1:0]          state_dbg;

  modport master (
    output tick_en, req, delay, abort,
    input  gnt, done, busy, count, state_dbg
  );

  modport slave (
    input  tick_en, req, delay, abort,
    output gnt, done, busy, count, state_dbg
  );

endinterface

// File: rtl/timer_sched_interval_ctr.sv
// Loadable interval up-counter: load latches the terminal value and clears,
// clr clears, en advances until count equals the terminal value.
module sched_interval_ctr #(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic [BITS-1:0] load_val,
    input  logic            clr,
    input  logic            en,
    output logic [BITS-1:0] count,
    output logic            expire
);

  logic [BITS-1:0] fin;

  // Holding at the terminal value means the increment can never wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      fin   <= '0;
    end else if (load) begin
      count <= '0;
      fin   <= load_val;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != fin)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = en && (count == fin);

endmodule

// File: rtl/timer_sched.sv
// Shared interval timer: arbitrates N requesters onto one counter and pulses
// done to the winner. Define TIMER_SCHED_RR_EN for round-robin arbitration.
import timer_sched_pkg::*;

module timer_sched #(
    parameter int N    = 4,
    parameter int BITS = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    timer_sched_if.slave  bus
);

  localparam int IW = $clog2(N);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    win_idx;
  logic [N-1:0]     win_oh;
  logic [N_MAX-1:0] oh_wide;
  logic [N-1:0]     gnt_q;
  logic [N-1:0]     done_q;
  logic [BITS-1:0]  count_w;
  logic             found;
  logic             ctr_load;
  logic             ctr_clr;
  logic             ctr_en;
  logic             expire;

`ifdef TIMER_SCHED_RR_EN
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] idx_next;
  int            j;

  assign idx_next = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;

  // Scan starts at rr_ptr and wraps, so the last owner goes to the back.
  always_comb begin
    win_oh = '0;
    found  = 1'b0;
    j      = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(rr_ptr) + i) % N;
      if (!found && bus.req[j]) begin
        win_oh[j] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if ((state == ST_RUN && bus.abort) || state == ST_DONE) begin
      rr_ptr <= idx_next;
    end
  end
`else
  always_comb begin
    win_oh = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && bus.req[i]) begin
        win_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    oh_wide        = '0;
    oh_wide[N-1:0] = win_oh;
  end

  assign win_idx  = IW'(onehot_to_idx(oh_wide));
  assign ctr_load = (state == ST_IDLE) && (|bus.req);
  assign ctr_clr  = (state == ST_RUN) && bus.abort;
  assign ctr_en   = (state == ST_RUN) && bus.tick_en;

  sched_interval_ctr #(.BITS(BITS)) u_ctr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (ctr_load),
    .load_val (bus.delay[int'(win_idx)*BITS +: BITS]),
    .clr      (ctr_clr),
    .en       (ctr_en),
    .count    (count_w),
    .expire   (expire)
  );

  // Abort is checked before expiry so a same-cycle abort suppresses done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      gnt_q  <= '0;
      done_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= '0;
          if (|bus.req) begin
            state <= ST_RUN;
            idx   <= win_idx;
            gnt_q <= win_oh;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state <= ST_IDLE;
            gnt_q <= '0;
          end else if (expire) begin
            state  <= ST_DONE;
            gnt_q  <= '0;
            done_q <= {{(N-1){1'b0}}, 1'b1} << idx;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= '0;
        end
        default: begin
          state  <= ST_IDLE;
          gnt_q  <= '0;
          done_q <= '0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.count     = count_w;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_timer_sched.sv
// Self-checking bench for timer_sched: directed scenarios plus random traffic
// compared each cycle against a remaining-ticks reference model.
module tb_timer_sched;

  localparam int N    = 4;
  localparam int BITS = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  timer_sched_if #(.N(N), .BITS(BITS)) bus ();

  timer_sched #(.N(N), .BITS(BITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model: phase 0 idle, 1 owner counting, 2 done pulse
  int m_phase, m_owner, m_fin, m_rem, m_count, m_ptr;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
`ifdef TIMER_SCHED_RR_EN
    for (int i = 0; i < N; i++) begin
      if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (r[i]) return i;
    end
`endif
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_fin = 0; m_rem = 0; m_count = 0; m_ptr = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [N-1:0] oh;
    case (m_phase)
      0: begin
        if (bus.req != '0) begin
          m_owner = pick(bus.req);
          m_fin   = int'(bus.delay[m_owner*BITS +: BITS]);
          m_rem   = m_fin + 1;
          m_count = 0;
          m_phase = 1;
          oh = '0;
          oh[m_owner] = 1'b1;
          exp_q.push_back(oh);
        end
      end
      1: begin
        if (bus.abort) begin
          m_phase = 0;
          m_count = 0;
          m_ptr   = (m_owner + 1) % N;
          void'(exp_q.pop_back());
        end else if (bus.tick_en) begin
          if (m_rem == 1) m_phase = 2;
          else begin
            m_rem   = m_rem - 1;
            m_count = m_fin + 1 - m_rem;
          end
        end
      end
      default: begin
        m_phase = 0;
        m_ptr   = (m_owner + 1) % N;
      end
    endcase
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_gnt, e_done;
    e_gnt = '0;
    e_done = '0;
    if (m_phase == 1) e_gnt[m_owner] = 1'b1;
    if (m_phase == 2) e_done[m_owner] = 1'b1;
    check("gnt",   bus.gnt,   e_gnt);
    check("done",  bus.done,  e_done);
    check("busy",  bus.busy,  m_phase != 0);
    check("count", bus.count, m_count);
    if (bus.done != '0) begin
      if (exp_q.size() == 0) check("done_spurious", bus.done, 0);
      else check("done_order", bus.done, exp_q.pop_front());
    end
  endtask

  // driver: one clock of the DUT and the model, then compare
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_delay(input int i, input int v);
    bus.delay[i*BITS +: BITS] = BITS'(v);
  endtask

  task automatic clear_inputs();
    bus.req = '0; bus.delay = '0; bus.abort = 1'b0; bus.tick_en = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_gnt",   bus.gnt,   0);
    check("rst_done",  bus.done,  0);
    check("rst_busy",  bus.busy,  0);
    check("rst_count", bus.count, 0);
    reset_n = 1'b1;

    // single requester, delay 3, continuous ticks
    bus.req = 4'b0001; set_delay(0, 3); bus.tick_en = 1'b1;
    cycle();
    bus.req = '0;
    repeat (6) cycle();

    // tick every third cycle, requester 1, delay 2
    bus.req = 4'b0010; set_delay(1, 2);
    for (int c = 0; c < 16; c++) begin
      bus.tick_en = (c % 3 == 2);
      cycle();
      bus.req = '0;
    end

    // all requesters, delay 0: arbitration order
    bus.delay = '0; bus.tick_en = 1'b1; bus.req = 4'b1111;
    repeat (16) cycle();
    bus.req = '0;
    repeat (3) cycle();

    // full-range delay must reach all-ones without wrapping
    bus.req = 4'b0001; set_delay(0, 15);
    cycle();
    bus.req = '0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (bus.done[0]) check("max_count", bus.count, 15);
    end

    // abort at count 2 of delay 5 on requester 2
    bus.req = 4'b0100; set_delay(2, 5);
    cycle();
    bus.req = '0;
    for (int c = 0; c < 10; c++) begin
      if (m_phase == 1 && m_count == 2) begin
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_count", bus.count, 0);
        break;
      end
      cycle();
    end
    repeat (2) cycle();
    bus.delay = '0; bus.req = 4'b1111;
    cycle();
`ifdef TIMER_SCHED_RR_EN
    check("abort_next", bus.gnt, 4'b1000);
`else
    check("abort_next", bus.gnt, 4'b0001);
`endif
    bus.req = '0;
    repeat (4) cycle();

    // asynchronous reset in the middle of an interval
    bus.req = 4'b0010; set_delay(1, 7);
    cycle();
    bus.req = '0;
    for (int c = 0; c < 20; c++) begin
      if (m_phase == 1 && m_count == 4) break;
      cycle();
    end
    check("pre_rst_count", bus.count, 4);
    #2 reset_n = 1'b0;
    #1;
    check("arst_gnt",   bus.gnt,   0);
    check("arst_done",  bus.done,  0);
    check("arst_busy",  bus.busy,  0);
    check("arst_count", bus.count, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    bus.req = 4'b1111; bus.delay = '0;
    cycle();
    check("post_rst_gnt", bus.gnt, 4'b0001);
    bus.req = '0;
    repeat (4) cycle();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      bus.req     = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
      bus.delay   = (N*BITS)'($urandom);
      bus.tick_en = ($urandom_range(0, 1) == 1);
      bus.abort   = ($urandom_range(0, 15) == 0);
      cycle();
    end
    clear_inputs();
    bus.tick_en = 1'b1;
    repeat (20) cycle();
    check("q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
